cp0_regfile: RTL and testbench
==============================

// Module: cp0_regfile
// PURPOSE
// - MIPS coprocessor 0: holds SR(12), Cause(13), EPC(14) and PRId(15), and serves mfc0/mtc0/eret.
// - Decides exception and interrupt entry; drives the flush/redirect request to the pipeline.
// - Sits in the M stage, directly downstream of the EPC calculator.
// - epc_in is the return address, already word-aligned and branch-delay adjusted upstream.
// PARAMETERS
// - PRID    32'h0019_1217  value returned by PRId reads; read-only
// - HW_INT  6              number of hardware interrupt lines, mapped to IM/IP bits [15:10]
// PORTS
// - clk       in   1       single system clock; all state updates on posedge
// - reset     in   1       synchronous, active-high
// - rd_addr   in   5       mfc0 register number
// - wr_addr   in   5       mtc0 register number
// - wr_data   in   32      mtc0 data
// - we        in   1       mtc0 write enable
// - epc_in    in   32      return address from the EPC calculator
// - bd_in     in   1       current M-stage instruction is in a delay slot
// - exc_code  in   5       pending exception code; 0 = none
// - hw_int    in   HW_INT  device interrupt lines; level-sensitive
// - exl_clr   in   1       eret in M stage
// - rd_data   out  32      mfc0 read data; combinational
// - epc_out   out  32      current EPC, used as the eret target
// - int_req   out  1       take exception/interrupt this cycle; pipeline flushes and jumps to 0x4180
// BEHAVIOUR
// - Reset clears SR, Cause and EPC to 0. After reset: int_req=0, epc_out=0, rd_data of PRId = PRID.
// - SR fields (others read 0):
//   - IM = [15:10]
//   - EXL = [1]
//   - IE = [0]
// - Cause fields (others read 0):
//   - BD = [31]
//   - IP = [15:10]
//   - ExcCode = [6:2]
// - Cause.IP is loaded from hw_int every cycle, including during reset release. It is not writable by mtc0.
// - int_pend = |(hw_int & SR.IM) & SR.IE & ~SR.EXL
// - exc_pend = (exc_code != 0) & ~SR.EXL
// - int_req  = int_pend | exc_pend. It is combinational, in the same cycle as its inputs.
// - Entry (int_req=1) at the posedge:
//   - EXL <= 1
//   - Cause.BD <= bd_in
//   - EPC <= epc_in
//   - Cause.ExcCode <= 0 if int_pend, else exc_code
// - Interrupt has priority over a synchronous exception in the same cycle.
// - Write priority (highest first): entry > exl_clr > mtc0. A mtc0 in the entry cycle is dropped, since that instruction is flushed.
// - exl_clr=1 without entry: EXL <= 0. A new int_req can assert no earlier than the next cycle.
// - mtc0:
//   - we=1 with wr_addr 12 writes IM, EXL and IE only.
//   - wr_addr 14 writes EPC with bits [1:0] forced to 0.
//   - Writes to 13, 15 or any other address are ignored.
// - mfc0: rd_data = selected register (12/13/14/15). Any other address returns 0. No bypass of a same-cycle write.
// - epc_out = EPC register. A same-cycle write becomes visible on the next cycle.
// - exc_code nonzero while EXL=1: ignored, no state change (nested exceptions unsupported).
// - Reset asserted during an entry cycle: reset wins and all fields go to 0.
// STRUCTURE
// - Shared package cp0_pkg holds:
//   - register numbers: CP0_SR=12, CP0_CAUSE=13, CP0_EPC=14, CP0_PRID=15
//   - ExcCode constants: Int=0, AdEL=4, AdES=5, RI=10, Ov=12
//   - bit-position constants for IM, EXL, IE, BD, IP and ExcCode
//   - handler address 32'h0000_4180
// - Sub-module cp0_req_gen (combinational): computes int_pend, exc_pend, int_req and the ExcCode to latch.
// - The top level holds the registers and the write-priority mux.
// TESTING
// - Reset: pulse reset, read 12/13/14 -> 0. Read 15 -> PRID. int_req=0.
// - Interrupt path:
//   - Stimulus: mtc0 SR=32'h0000_0401 (IM[10], IE), hw_int=6'b000001, epc_in=32'h3010, bd_in=0.
//   - Response: int_req=1 the same cycle. Next cycle: EPC=32'h3010, Cause.ExcCode=0, EXL=1, int_req=0.
// - Exception in delay slot: exc_code=10, bd_in=1, epc_in=32'h3008 -> EPC=32'h3008, Cause=32'h8000_0028.
// - Same-cycle entry + mtc0 to EPC with 32'hFFFF: entry wins and EPC=epc_in.
//   - Separately, mtc0 EPC=32'h3007 -> epc_out=32'h3004 on the next cycle.
// - eret: exl_clr=1 with EXL=1 and masked-in hw_int held high.
//   - Response: int_req=0 in that cycle, EXL=0 after the posedge, int_req=1 the following cycle.
// - Masking: IE=0 or EXL=1 with hw_int active -> int_req stays 0. Cause.IP tracks hw_int every cycle.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared definitions for the coprocessor-0 register file.
// Contents:
//   - CP0 register numbers used by mfc0/mtc0 decoding
//   - ExcCode values written into Cause
//   - bit positions of the SR and Cause fields
//   - exception handler entry address
package cp0_pkg;

    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    // SR fields
    localparam int unsigned SR_IM_LO     = 10;
    localparam int unsigned SR_IM_HI     = 15;
    localparam int unsigned SR_EXL       = 1;
    localparam int unsigned SR_IE        = 0;

    // Cause fields
    localparam int unsigned CAUSE_BD     = 31;
    localparam int unsigned CAUSE_IP_LO  = 10;
    localparam int unsigned CAUSE_IP_HI  = 15;
    localparam int unsigned CAUSE_EXC_LO = 2;
    localparam int unsigned CAUSE_EXC_HI = 6;

    localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

endpackage

// File: rtl/cp0_req_gen.sv
// Exception/interrupt entry decision (purely combinational).
// Ports:
//   i_im        SR.IM interrupt mask
//   i_hw_int    device interrupt lines (level)
//   i_exl       SR.EXL
//   i_ie        SR.IE
//   i_exc_code  pending synchronous exception code, 0 = none
//   o_int_pend  masked interrupt pending and enabled
//   o_exc_pend  synchronous exception pending
//   o_int_req   take entry this cycle
//   o_exc_code  ExcCode to latch into Cause on entry
module cp0_req_gen
    import cp0_pkg::*;
#(
    parameter int unsigned HW_INT = 6
) (
    input  logic [HW_INT-1:0] i_im,
    input  logic [HW_INT-1:0] i_hw_int,
    input  logic              i_exl,
    input  logic              i_ie,
    input  logic [4:0]        i_exc_code,
    output logic              o_int_pend,
    output logic              o_exc_pend,
    output logic              o_int_req,
    output logic [4:0]        o_exc_code
);

    always_comb begin
        o_int_pend = (|(i_hw_int & i_im)) & i_ie & ~i_exl;
        o_exc_pend = (i_exc_code != 5'd0) & ~i_exl;
        o_int_req  = o_int_pend | o_exc_pend;
        // Interrupt outranks a simultaneous synchronous exception.
        o_exc_code = o_int_pend ? EXC_INT : i_exc_code;
    end

endmodule

// File: rtl/cp0_regfile.sv
// MIPS coprocessor 0: SR, Cause, EPC and PRId with mfc0/mtc0/eret support
// and exception/interrupt entry. Sits in the M stage.
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   rd_addr      mfc0 register number; rd_data is combinational
//   wr_addr/wr_data/we   mtc0 write
//   epc_in       word-aligned, delay-slot-adjusted return address
//   bd_in        M-stage instruction sits in a delay slot
//   exc_code     pending exception code, 0 = none
//   hw_int       level-sensitive device interrupt lines
//   exl_clr      eret in M stage
//   rd_data      mfc0 read data
//   epc_out      current EPC (eret target)
//   int_req      take exception/interrupt this cycle (flush, jump to handler)
module cp0_regfile
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID   = 32'h0019_1217,
    parameter int unsigned HW_INT = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        rd_addr,
    input  logic [4:0]        wr_addr,
    input  logic [31:0]       wr_data,
    input  logic              we,
    input  logic [31:0]       epc_in,
    input  logic              bd_in,
    input  logic [4:0]        exc_code,
    input  logic [HW_INT-1:0] hw_int,
    input  logic              exl_clr,
    output logic [31:0]       rd_data,
    output logic [31:0]       epc_out,
    output logic              int_req
);

    logic [HW_INT-1:0] r_im;
    logic              r_exl;
    logic              r_ie;
    logic              r_bd;
    logic [HW_INT-1:0] r_ip;
    logic [4:0]        r_exc;
    logic [31:0]       r_epc;

    logic              w_int_pend;
    logic              w_exc_pend;
    logic              w_int_req;
    logic [4:0]        w_exc_code;
    logic [31:0]       w_sr;
    logic [31:0]       w_cause;

    cp0_req_gen #(
        .HW_INT (HW_INT)
    ) u_req_gen (
        .i_im       (r_im),
        .i_hw_int   (hw_int),
        .i_exl      (r_exl),
        .i_ie       (r_ie),
        .i_exc_code (exc_code),
        .o_int_pend (w_int_pend),
        .o_exc_pend (w_exc_pend),
        .o_int_req  (w_int_req),
        .o_exc_code (w_exc_code)
    );

    // IP mirrors the interrupt lines every cycle, independent of reset.
    always_ff @(posedge clk) begin
        r_ip <= hw_int;
    end

    // Priority: reset > entry > eret > mtc0. A mtc0 in an entry cycle
    // belongs to the flushed instruction and is discarded.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_im  <= '0;
            r_exl <= 1'b0;
            r_ie  <= 1'b0;
            r_bd  <= 1'b0;
            r_exc <= '0;
            r_epc <= '0;
        end else if (w_int_req) begin
            r_exl <= 1'b1;
            r_bd  <= bd_in;
            r_epc <= epc_in;
            r_exc <= w_exc_code;
        end else if (exl_clr) begin
            r_exl <= 1'b0;
        end else if (we) begin
            case (wr_addr)
                CP0_SR: begin
                    r_im  <= wr_data[SR_IM_LO +: HW_INT];
                    r_exl <= wr_data[SR_EXL];
                    r_ie  <= wr_data[SR_IE];
                end
                CP0_EPC: r_epc <= {wr_data[31:2], 2'b00};
                default: ;
            endcase
        end
    end

    always_comb begin
        w_sr                              = '0;
        w_sr[SR_IM_LO +: HW_INT]          = r_im;
        w_sr[SR_EXL]                      = r_exl;
        w_sr[SR_IE]                       = r_ie;

        w_cause                           = '0;
        w_cause[CAUSE_BD]                 = r_bd;
        w_cause[CAUSE_IP_LO +: HW_INT]    = r_ip;
        w_cause[CAUSE_EXC_LO +: 5]        = r_exc;
    end

    always_comb begin
        rd_data = '0;
        case (rd_addr)
            CP0_SR:    rd_data = w_sr;
            CP0_CAUSE: rd_data = w_cause;
            CP0_EPC:   rd_data = r_epc;
            CP0_PRID:  rd_data = PRID;
            default:   rd_data = '0;
        endcase
    end

    assign epc_out = r_epc;
    assign int_req = w_int_req;

endmodule

// File: tb/tb_cp0_regfile.sv
module tb_cp0_regfile;

    localparam logic [31:0] PRID_V = 32'h0019_1217;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rd_addr, wr_addr, exc_code;
    logic [31:0] wr_data, epc_in;
    logic        we, bd_in, exl_clr;
    logic [5:0]  hw_int;
    logic [31:0] rd_data, epc_out;
    logic        int_req;

    always #5 clk = ~clk;

    cp0_regfile #(
        .PRID   (PRID_V),
        .HW_INT (6)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rd_addr  (rd_addr),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .we       (we),
        .epc_in   (epc_in),
        .bd_in    (bd_in),
        .exc_code (exc_code),
        .hw_int   (hw_int),
        .exl_clr  (exl_clr),
        .rd_data  (rd_data),
        .epc_out  (epc_out),
        .int_req  (int_req)
    );

    typedef struct {
        logic        rst;
        logic [4:0]  rd;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] epc;
        logic        bd;
        logic [4:0]  exc;
        logic [5:0]  hw;
        logic        clr;
        logic        req;
        logic [31:0] rdv;
        logic [31:0] epcv;
        logic        chk;
    } vec_t;

    typedef struct {
        int          tag;
        logic        chk;
        logic        req;
        logic [31:0] rdv;
        logic [31:0] epcv;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   passed = 0;
    int   total  = 0;

    function automatic vec_t v(logic rst, logic [4:0] rd, logic we_i, logic [4:0] wa,
                               logic [31:0] wd, logic [31:0] epc, logic bd, logic [4:0] exc,
                               logic [5:0] hw, logic clr, logic req, logic [31:0] rdv,
                               logic [31:0] epcv, logic chk = 1'b1);
        vec_t r;
        r.rst = rst; r.rd = rd; r.we = we_i; r.wa = wa; r.wd = wd; r.epc = epc;
        r.bd = bd; r.exc = exc; r.hw = hw; r.clr = clr; r.req = req; r.rdv = rdv;
        r.epcv = epcv; r.chk = chk;
        return r;
    endfunction

    task automatic apply(input vec_t x, input int tag);
        exp_t e;
        @(posedge clk);
        #1;
        reset = x.rst; rd_addr = x.rd; we = x.we; wr_addr = x.wa; wr_data = x.wd;
        epc_in = x.epc; bd_in = x.bd; exc_code = x.exc; hw_int = x.hw; exl_clr = x.clr;
        e.tag = tag; e.chk = x.chk; e.req = x.req; e.rdv = x.rdv; e.epcv = x.epcv;
        exp_q.push_back(e);
    endtask

    task automatic check32(input string name, input int tag, input logic [31:0] act,
                           input logic [31:0] expv);
        total++;
        if (act === expv) passed++;
        else $display("FAIL %s step %0d: got %h want %h", name, tag, act, expv);
    endtask

    // Monitor: compare outputs mid-cycle against the oldest queued expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.chk) begin
                check32("int_req", e.tag, {31'b0, int_req}, {31'b0, e.req});
                check32("rd_data", e.tag, rd_data, e.rdv);
                check32("epc_out", e.tag, epc_out, e.epcv);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [5:0] prev_hw;
        logic [5:0] hw_r;
        reset = 1'b1; rd_addr = '0; we = 1'b0; wr_addr = '0; wr_data = '0;
        epc_in = '0; bd_in = 1'b0; exc_code = '0; hw_int = '0; exl_clr = 1'b0;

        //            rst rd  we wa  wd             epc           bd exc hw      clr req rdv            epcv
        // reset and read-back
        vecs.push_back(v(1, 15, 0, 0, 0,            0,            0, 0,  6'd0,  0,  0, 0,            0, 0));
        vecs.push_back(v(0, 12, 0, 0, 0,            0,            0, 0,  6'd0,  0,  0, 0,            0));
        vecs.push_back(v(0, 13, 0, 0, 0,            0,            0, 0,  6'd0,  0,  0, 0,            0));
        vecs.push_back(v(0, 14, 0, 0, 0,            0,            0, 0,  6'd0,  0,  0, 0,            0));
        vecs.push_back(v(0, 15, 0, 0, 0,            0,            0, 0,  6'd0,  0,  0, PRID_V,       0));
        vecs.push_back(v(0, 20, 0, 0, 0,            0,            0, 0,  6'd0,  0,  0, 0,            0));
        // interrupt path
        vecs.push_back(v(0, 12, 1, 12, 32'h401,     0,            0, 0,  6'd0,  0,  0, 0,            0));
        vecs.push_back(v(0, 12, 0, 0, 0,            32'h3010,     0, 0,  6'd1,  0,  1, 32'h401,      0));
        vecs.push_back(v(0, 13, 0, 0, 0,            0,            0, 0,  6'd1,  0,  0, 32'h400,      32'h3010));
        vecs.push_back(v(0, 12, 0, 0, 0,            0,            0, 0,  6'd1,  0,  0, 32'h403,      32'h3010));
        // eret with masked-in interrupt held high
        vecs.push_back(v(0, 12, 0, 0, 0,            0,            0, 0,  6'd1,  1,  0, 32'h403,      32'h3010));
        vecs.push_back(v(0, 12, 0, 0, 0,            32'h3020,     0, 0,  6'd1,  0,  1, 32'h401,      32'h3010));
        vecs.push_back(v(0, 14, 0, 0, 0,            0,            0, 0,  6'd0,  0,  0, 32'h3020,     32'h3020));
        // masking: IE=0
        vecs.push_back(v(0, 13, 1, 12, 32'h400,     0,            0, 0,  6'd0,  0,  0, 0,            32'h3020));
        vecs.push_back(v(0, 12, 0, 0, 0,            0,            0, 0,  6'd1,  0,  0, 32'h400,      32'h3020));
        vecs.push_back(v(0, 13, 0, 0, 0,            0,            0, 0,  6'd1,  0,  0, 32'h400,      32'h3020));
        // exception in delay slot, then ignored while EXL=1
        vecs.push_back(v(0, 12, 0, 0, 0,            32'h3008,     1, 10, 6'd0,  0,  1, 32'h400,      32'h3020));
        vecs.push_back(v(0, 13, 0, 0, 0,            32'h5554,     0, 10, 6'd0,  0,  0, 32'h8000_0028, 32'h3008));
        vecs.push_back(v(0, 14, 0, 0, 0,            0,            0, 0,  6'd0,  0,  0, 32'h3008,     32'h3008));
        // entry and mtc0 EPC in the same cycle
        vecs.push_back(v(0, 12, 0, 0, 0,            0,            0, 0,  6'd0,  1,  0, 32'h402,      32'h3008));
        vecs.push_back(v(0, 13, 1, 14, 32'hFFFF,    32'h3040,     0, 12, 6'd0,  0,  1, 32'h8000_0028, 32'h3008));
        vecs.push_back(v(0, 14, 0, 0, 0,            0,            0, 0,  6'd0,  0,  0, 32'h3040,     32'h3040));
        vecs.push_back(v(0, 13, 0, 0, 0,            0,            0, 0,  6'd0,  0,  0, 32'h30,       32'h3040));
        // mtc0 EPC alignment, no same-cycle bypass
        vecs.push_back(v(0, 14, 1, 14, 32'h3007,    0,            0, 0,  6'd0,  0,  0, 32'h3040,     32'h3040));
        vecs.push_back(v(0, 14, 0, 0, 0,            0,            0, 0,  6'd0,  0,  0, 32'h3004,     32'h3004));
        // writes to Cause / PRId ignored
        vecs.push_back(v(0, 13, 1, 13, 32'hFFFF_FFFF, 0,          0, 0,  6'd0,  0,  0, 32'h30,       32'h3004));
        vecs.push_back(v(0, 15, 1, 15, 0,           0,            0, 0,  6'd0,  0,  0, PRID_V,       32'h3004));
        vecs.push_back(v(0, 13, 0, 0, 0,            0,            0, 0,  6'd0,  0,  0, 32'h30,       32'h3004));
        vecs.push_back(v(0, 15, 0, 0, 0,            0,            0, 0,  6'd0,  0,  0, PRID_V,       32'h3004));
        // interrupt beats exception in the same cycle
        vecs.push_back(v(0, 12, 1, 12, 32'h401,     0,            0, 0,  6'd0,  0,  0, 32'h402,      32'h3004));
        vecs.push_back(v(0, 12, 0, 0, 0,            32'h3050,     0, 4,  6'd1,  0,  1, 32'h401,      32'h3004));
        vecs.push_back(v(0, 13, 0, 0, 0,            0,            0, 0,  6'd0,  0,  0, 32'h400,      32'h3050));
        // reset during an entry cycle
        vecs.push_back(v(0, 12, 0, 0, 0,            0,            0, 0,  6'd0,  1,  0, 32'h403,      32'h3050));
        vecs.push_back(v(1, 12, 0, 0, 0,            32'h3060,     1, 5,  6'd0,  0,  1, 32'h401,      32'h3050));
        vecs.push_back(v(0, 14, 0, 0, 0,            0,            0, 0,  6'd0,  0,  0, 0,            0));
        vecs.push_back(v(0, 12, 0, 0, 0,            0,            0, 0,  6'd0,  0,  0, 0,            0));
        vecs.push_back(v(0, 13, 0, 0, 0,            0,            0, 0,  6'd0,  0,  0, 0,            0));
        // interrupt on an unmasked line only
        vecs.push_back(v(0, 12, 1, 12, 32'h801,     0,            0, 0,  6'd0,  0,  0, 0,            0));
        vecs.push_back(v(0, 12, 0, 0, 0,            0,            0, 0,  6'd1,  0,  0, 32'h801,      0));
        vecs.push_back(v(0, 13, 0, 0, 0,            32'h3070,     0, 0,  6'd2,  0,  1, 32'h400,      0));
        vecs.push_back(v(0, 13, 0, 0, 0,            0,            0, 0,  6'd0,  0,  0, 32'h800,      32'h3070));

        foreach (vecs[i]) apply(vecs[i], i);

        // Cause.IP follows random interrupt lines one cycle later; EXL=1 keeps int_req low.
        prev_hw = 6'd0;
        for (int k = 0; k < 8; k++) begin
            vec_t x;
            hw_r = 6'($urandom_range(0, 63));
            x = v(0, 13, 0, 0, 0, 0, 0, 0, hw_r, 0, 0, {16'b0, prev_hw, 10'b0}, 32'h3070);
            apply(x, 100 + k);
            prev_hw = hw_r;
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL drain: got %0d pending want 0", exp_q.size());

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
